// File: rtl/traffic_light_pkg.sv
// Shared state encoding and lamp patterns for the two-way traffic light controller.
// Lamp vectors are packed as {red1, yellow1, green1, red2, yellow2, green2}.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    R1G2,
    R1Y2,
    RR_A,
    G1R2,
    Y1R2,
    RR_B,
    FLASH
  } state_t;

  localparam logic [5:0] LAMPS_R1G2     = 6'b100_001;
  localparam logic [5:0] LAMPS_R1Y2     = 6'b100_010;
  localparam logic [5:0] LAMPS_RR       = 6'b100_100;
  localparam logic [5:0] LAMPS_G1R2     = 6'b001_100;
  localparam logic [5:0] LAMPS_Y1R2     = 6'b010_100;
  localparam logic [5:0] LAMPS_FLASH_ON = 6'b010_010;
  localparam logic [5:0] LAMPS_OFF      = 6'b000_000;

  function automatic state_t next_normal(input state_t s);
    case (s)
      R1G2:    return R1Y2;
      R1Y2:    return RR_A;
      RR_A:    return G1R2;
      G1R2:    return Y1R2;
      Y1R2:    return RR_B;
      default: return R1G2;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_controller_flasher.sv
// Flash-mode blinker: half-period counter plus on/off phase toggle.
// While clr is high the phase is held on and the counter held at zero.
module tl_flasher #(
  parameter int HALF_CYCLES = 8_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic phase
);

  localparam int CW = $clog2(HALF_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/traffic_light_controller.sv
// Six-phase two-way traffic light sequencer with a flashing-yellow override mode.
// Lamps are decoded from registered state only, so mode_switch never reaches them combinationally.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYCLES      = 160_000_000,
  parameter int YELLOW_CYCLES     = 48_000_000,
  parameter int RED_RED_CYCLES    = 16_000_000,
  parameter int FLASH_HALF_CYCLES = 8_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_switch,
  output logic red1,
  output logic yellow1,
  output logic green1,
  output logic red2,
  output logic yellow2,
  output logic green2
);

  localparam int MAX_GY     = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int MAX_RF     = (RED_RED_CYCLES > FLASH_HALF_CYCLES) ? RED_RED_CYCLES : FLASH_HALF_CYCLES;
  localparam int MAX_CYCLES = (MAX_GY > MAX_RF) ? MAX_GY : MAX_RF;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RR_LAST     = CNT_W'(RED_RED_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;
  logic             flash_clr;
  logic             flash_phase;
  logic [5:0]       lamps;

  always_comb begin
    case (state_q)
      R1G2, G1R2: last_cnt = GREEN_LAST;
      R1Y2, Y1R2: last_cnt = YELLOW_LAST;
      RR_A, RR_B: last_cnt = RR_LAST;
      default:    last_cnt = '0;
    endcase
  end

  // Flash has priority from any state; leaving flash always restarts with a full green.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mode_switch) begin
      state_d = FLASH;
      cnt_d   = '0;
    end else if (state_q == FLASH) begin
      state_d = R1G2;
      cnt_d   = '0;
    end else if (cnt_q == last_cnt) begin
      state_d = next_normal(state_q);
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R1G2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding the blinker cleared outside FLASH makes every entry start on a fresh "on" half.
  assign flash_clr = (state_q != FLASH);

  tl_flasher #(
    .HALF_CYCLES(FLASH_HALF_CYCLES)
  ) u_flasher (
    .clk  (clk),
    .rst  (rst),
    .clr  (flash_clr),
    .phase(flash_phase)
  );

  always_comb begin
    case (state_q)
      R1G2:       lamps = LAMPS_R1G2;
      R1Y2:       lamps = LAMPS_R1Y2;
      RR_A, RR_B: lamps = LAMPS_RR;
      G1R2:       lamps = LAMPS_G1R2;
      Y1R2:       lamps = LAMPS_Y1R2;
      FLASH:      lamps = flash_phase ? LAMPS_FLASH_ON : LAMPS_OFF;
      default:    lamps = LAMPS_R1G2;
    endcase
  end

  assign {red1, yellow1, green1, red2, yellow2, green2} = lamps;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed plus randomized bench for traffic_light_controller, checked against a
// time-based reference: lamps are derived from elapsed clocks since sequence or flash start.
`timescale 1ns/1ps
module tb_traffic_light_controller;

  localparam int G   = 30;
  localparam int Y   = 5;
  localparam int RR  = 2;
  localparam int H   = 5;
  localparam int PER = 2 * (G + Y + RR);

  logic clk = 1'b0;
  logic rst;
  logic mode_switch;
  logic red1, yellow1, green1, red2, yellow2, green2;

  int tests = 0;
  int fails = 0;

  // Reference state: clocks elapsed since the normal sequence (re)started at R1G2,
  // or since flash mode was entered.
  int seq_t   = 0;
  int flash_t = 0;
  bit in_flash = 1'b0;

  traffic_light_controller #(
    .GREEN_CYCLES     (G),
    .YELLOW_CYCLES    (Y),
    .RED_RED_CYCLES   (RR),
    .FLASH_HALF_CYCLES(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_switch(mode_switch),
    .red1       (red1),
    .yellow1    (yellow1),
    .green1     (green1),
    .red2       (red2),
    .yellow2    (yellow2),
    .green2     (green2)
  );

  always #31.25 clk = ~clk;

  function automatic logic [5:0] model_lamps(input bit fl, input int st, input int ft);
    int pos;
    if (fl) return (((ft / H) % 2) == 0) ? 6'b010_010 : 6'b000_000;
    pos = st % PER;
    if (pos < G)                return 6'b100_001;
    if (pos < G + Y)            return 6'b100_010;
    if (pos < G + Y + RR)       return 6'b100_100;
    if (pos < 2*G + Y + RR)     return 6'b001_100;
    if (pos < 2*G + 2*Y + RR)   return 6'b010_100;
    return 6'b100_100;
  endfunction

  task automatic check(input string tag);
    logic [5:0] obs;
    logic [5:0] exp_l;
    logic       inv_ok;
    obs   = {red1, yellow1, green1, red2, yellow2, green2};
    exp_l = model_lamps(in_flash, seq_t, flash_t);
    tests++;
    assert (obs === exp_l) else begin
      fails++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp_l);
    end
    if (in_flash)
      inv_ok = !red1 && !green1 && !red2 && !green2 && (yellow1 === yellow2);
    else
      inv_ok = ((int'(red1) + int'(yellow1) + int'(green1)) == 1) &&
               ((int'(red2) + int'(yellow2) + int'(green2)) == 1) && !(green1 && green2);
    tests++;
    assert (inv_ok === 1'b1) else begin
      fails++;
      $error("FAIL invariant_%s t=%0t observed=%b expected=lamp_rules_ok", tag, $time, obs);
    end
  endtask

  task automatic step(input bit v, input string tag);
    mode_switch = v;
    @(posedge clk);
    if (!v) begin
      if (!in_flash) begin
        in_flash = 1'b1;
        flash_t  = 0;
      end else begin
        flash_t++;
      end
    end else begin
      if (in_flash) begin
        in_flash = 1'b0;
        seq_t    = 0;
      end else begin
        seq_t++;
      end
    end
    #1;
    check(tag);
  endtask

  // Asserts reset between edges, checks the immediate async effect, then releases
  // on a falling edge with the requested mode_switch level.
  task automatic do_reset(input bit ms_after);
    #10;
    rst = 1'b1;
    seq_t = 0; flash_t = 0; in_flash = 1'b0;
    #1;
    check("async_rst");
    mode_switch = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dominates");
    mode_switch = ms_after;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    mode_switch = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst");

    repeat (PER + 5) step(1'b1, "normal_cycle");

    found = 1'b0;
    for (int i = 0; i < PER && !found; i++) begin
      if ((seq_t % PER) == 10) found = 1'b1;
      else step(1'b1, "seek_green");
    end
    tests++;
    assert (found === 1'b1) else begin
      fails++;
      $error("FAIL seek_green_bound observed=%0d expected=%0d", seq_t % PER, 10);
    end

    step(1'b0, "flash_entry");
    repeat (160) step(1'b0, "flash_hold");
    step(1'b1, "resume");
    repeat (35) step(1'b1, "after_resume");

    found = 1'b0;
    for (int i = 0; i < PER && !found; i++) begin
      if ((seq_t % PER) == G + Y) found = 1'b1;
      else step(1'b1, "seek_rr");
    end
    tests++;
    assert (found === 1'b1) else begin
      fails++;
      $error("FAIL seek_rr_bound observed=%0d expected=%0d", seq_t % PER, G + Y);
    end
    do_reset(1'b1);
    repeat (40) step(1'b1, "after_rr_rst");

    repeat (7) step(1'b0, "pre_flash_rst");
    do_reset(1'b0);
    repeat (12) step(1'b0, "flash_after_rst");
    repeat (5) step(1'b1, "normal_after_rst");

    repeat (40) begin
      bit v;
      int n;
      v = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 45);
      repeat (n) step(v, "random");
      if ($urandom_range(0, 9) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
